la_counter_user_proj: RTL and testbench

User-area block for the management SoC's user project wrapper. It provides a 32-bit free-running counter that firmware controls over Wishbone and the logic analyzer (LA), plus a 16-bit check register driven onto user IO [31:16]. Firmware uses the check register to report test progress, e.g. 0xAB60 on start and 0xAB61 on pass. The counter is the LA-controlled object under test.

---
 rtl/la_counter_user_proj_if.sv | 21 ++
 rtl/la_counter_user_proj.sv | 85 ++++++++
 tb/tb_la_counter_user_proj.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/la_counter_user_proj_if.sv
// Wishbone slave bus between the management SoC and the user-area counter block.
interface la_counter_user_proj_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/la_counter_user_proj.sv
// 32-bit LA/Wishbone-controlled free-running counter plus a 16-bit check register on IO[31:16].
// Every Wishbone access acks one cycle after the request; no wait states, no backpressure.
module la_counter_user_proj #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  la_counter_user_proj_if.slave wbs,
  input  logic [127:0]          la_data_in,
  input  logic [127:0]          la_oenb,
  output logic [127:0]          la_data_out,
  input  logic [37:0]           io_in,
  output logic [37:0]           io_out,
  output logic [37:0]           io_oeb
);

  logic [CNT_W-1:0] count, count_nxt, count_inc, count_la, count_wb;
  logic [15:0]      check, check_nxt;
  logic             ack_q;
  logic [31:0]      dat_q, rd_data;
  logic             hit, valid, wr, soft_rst, freeze;
  logic [1:0]       reg_idx;

  always_comb begin
    hit      = (wbs.wbs_adr_i[31:4] == BASE_ADR[31:4]);
    valid    = wbs.wbs_stb_i & wbs.wbs_cyc_i & hit & ~ack_q;
    wr       = valid & wbs.wbs_we_i;
    reg_idx  = wbs.wbs_adr_i[3:2];
    soft_rst = ~la_oenb[64] & la_data_in[64];
    freeze   = ~la_oenb[65] & la_data_in[65];

    // LA-driven bits override the incremented (or held) value bit by bit
    count_inc = freeze ? count : count + 32'd1;
    count_la  = (count_inc & la_oenb[63:32]) | (la_data_in[63:32] & ~la_oenb[63:32]);

    count_wb = count;
    for (int b = 0; b < 4; b++) begin
      if (wbs.wbs_sel_i[b]) count_wb[8*b +: 8] = wbs.wbs_dat_i[8*b +: 8];
    end

    count_nxt = count_la;
    if (soft_rst)                   count_nxt = '0;
    else if (wr && reg_idx == 2'd0) count_nxt = count_wb;

    check_nxt = check;
    if (wr && reg_idx == 2'd1) begin
      if (wbs.wbs_sel_i[0]) check_nxt[7:0]  = wbs.wbs_dat_i[7:0];
      if (wbs.wbs_sel_i[1]) check_nxt[15:8] = wbs.wbs_dat_i[15:8];
    end

    case (reg_idx)
      2'd0:    rd_data = count;
      2'd1:    rd_data = {16'h0000, check};
      default: rd_data = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      count <= '0;
      check <= '0;
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      count <= count_nxt;
      check <= check_nxt;
      ack_q <= valid;
      if (valid) dat_q <= rd_data;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;

  assign la_data_out = {80'h0, check, count};
  // Only IO[31:16] is driven; everything else, including the housekeeping CSB, stays input
  assign io_out      = {6'h00, check, 16'h0000};
  assign io_oeb      = {6'h3F, 16'h0000, 16'hFFFF};

  logic unused_ok;
  assign unused_ok = &{1'b0, io_in, la_data_in[127:66], la_data_in[31:0],
                       la_oenb[127:66], la_oenb[31:0], wbs.wbs_adr_i[1:0]};

endmodule

// File: tb/tb_la_counter_user_proj.sv
// Directed bench for la_counter_user_proj: reset, Wishbone register table, LA load/freeze/soft reset, priority and abort cases.
module tb_la_counter_user_proj;

  logic         clk;
  logic         rst;
  logic [127:0] la_data_in, la_oenb, la_data_out;
  logic [37:0]  io_in, io_out, io_oeb;

  la_counter_user_proj_if wbs ();

  la_counter_user_proj dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs         (wbs.slave),
    .la_data_in  (la_data_in),
    .la_oenb     (la_oenb),
    .la_data_out (la_data_out),
    .io_in       (io_in),
    .io_out      (io_out),
    .io_oeb      (io_oeb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [37:0] OEB_EXP = {6'h3F, 32'h0000_FFFF};

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic        exp_ack;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Called at a negedge; holds the request two cycles to see a single ack pulse.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] wd, output logic a1, output logic a2,
                         output logic [31:0] rd, output logic [31:0] c1);
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_we_i  = we;
    wbs.wbs_adr_i = adr;
    wbs.wbs_sel_i = sel;
    wbs.wbs_dat_i = wd;
    @(negedge clk);
    a1 = wbs.wbs_ack_o;
    rd = wbs.wbs_dat_o;
    c1 = la_data_out[31:0];
    @(negedge clk);
    a2 = wbs.wbs_ack_o;
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
  endtask

  initial begin
    logic        a1, a2;
    logic [31:0] rd, c1, snap;
    bit          found;

    // we, adr, sel, wdata, exp_ack, check_rd, exp_rd  (count frozen at 0 on entry)
    vecs[0]  = '{1'b1, 32'h3000_0000, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h3000_0000, 4'hF, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h3000_0000, 4'hA, 32'h1122_3344, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h3000_0000, 4'hF, 32'h0,         1'b1, 1'b1, 32'h11AD_33EF};
    vecs[4]  = '{1'b1, 32'h3000_0004, 4'hF, 32'h0000_AB61, 1'b1, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h3000_0004, 4'hF, 32'h0,         1'b1, 1'b1, 32'h0000_AB61};
    vecs[6]  = '{1'b1, 32'h3000_0004, 4'hC, 32'hFFFF_1234, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h3000_0004, 4'hF, 32'h0,         1'b1, 1'b1, 32'h0000_AB61};
    vecs[8]  = '{1'b1, 32'h3000_0004, 4'h2, 32'h0000_5500, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h3000_0004, 4'hF, 32'h0,         1'b1, 1'b1, 32'h0000_5561};
    vecs[10] = '{1'b1, 32'h3000_000C, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h3000_000C, 4'hF, 32'h0,         1'b1, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 32'h3000_0008, 4'hF, 32'h0,         1'b1, 1'b1, 32'h0};
    vecs[13] = '{1'b1, 32'h3000_0010, 4'hF, 32'h1234_5678, 1'b0, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 32'h2000_0004, 4'hF, 32'h0,         1'b0, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 32'h3000_0004, 4'hF, 32'h0000_AB61, 1'b1, 1'b0, 32'h0};

    rst = 1'b1;
    la_data_in = '0;
    la_oenb    = '1;
    io_in      = '0;
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_sel_i = 4'h0;
    wbs.wbs_adr_i = '0;
    wbs.wbs_dat_i = '0;

    repeat (3) @(negedge clk);
    chk("rst_la_out", la_data_out, 128'h0);
    chk("rst_ack", {127'h0, wbs.wbs_ack_o}, 128'h0);
    chk("rst_dat", {96'h0, wbs.wbs_dat_o}, 128'h0);
    chk("rst_io_out", {90'h0, io_out}, 128'h0);
    chk("io_oeb", {90'h0, io_oeb}, {90'h0, OEB_EXP});

    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("count_10", {96'h0, la_data_out[31:0]}, 128'd10);

    // Check register write, single ack pulse, IO mirror, readback
    wb_xfer(1'b1, 32'h3000_0004, 4'hF, 32'h0000_AB60, a1, a2, rd, c1);
    chk("chk_wr_ack", {127'h0, a1}, 128'h1);
    chk("chk_wr_ack_pulse", {127'h0, a2}, 128'h0);
    chk("io_out_ab60", {90'h0, io_out}, {90'h0, 6'h0, 16'hAB60, 16'h0});
    chk("la_out_check", {112'h0, la_data_out[47:32]}, 128'hAB60);
    wb_xfer(1'b0, 32'h3000_0004, 4'hF, 32'h0, a1, a2, rd, c1);
    chk("chk_rd_ack", {127'h0, a1}, 128'h1);
    chk("chk_rd", {96'h0, rd}, 128'h0000_AB60);

    // Byte-masked COUNT write once the counter reaches 0x1234
    found = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (la_data_out[31:0] == 32'h0000_1234) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_1234", {127'h0, found}, 128'h1);
    if (found) begin
      wb_xfer(1'b1, 32'h3000_0000, 4'h1, 32'h0000_00FF, a1, a2, rd, c1);
      chk("cnt_byte_wr", {96'h0, c1}, 128'h12FF);
      chk("cnt_after_wr", {96'h0, la_data_out[31:0]}, 128'h1300);
    end
    wb_xfer(1'b0, 32'h3000_0008, 4'hF, 32'h0, a1, a2, rd, c1);
    chk("rd_08_ack", {127'h0, a1}, 128'h1);
    chk("rd_08", {96'h0, rd}, 128'h0);

    // LA load then wrap
    la_oenb[63:32]    = 32'h0;
    la_data_in[63:32] = 32'hFFFF_FFF0;
    @(negedge clk);
    la_oenb[63:32]    = 32'hFFFF_FFFF;
    la_data_in[63:32] = 32'h0;
    chk("la_load", {96'h0, la_data_out[31:0]}, 128'hFFFF_FFF0);
    repeat (15) @(negedge clk);
    chk("pre_wrap", {96'h0, la_data_out[31:0]}, 128'hFFFF_FFFF);
    @(negedge clk);
    chk("wrap", {96'h0, la_data_out[31:0]}, 128'h0);

    // Freeze for 20 cycles, then soft reset while frozen
    repeat (7) @(negedge clk);
    la_oenb[65]    = 1'b0;
    la_data_in[65] = 1'b1;
    snap = la_data_out[31:0];
    repeat (20) @(negedge clk);
    chk("freeze_hold", {96'h0, la_data_out[31:0]}, {96'h0, snap});
    chk("freeze_nonzero", {127'h0, snap == 32'd7}, 128'h1);
    la_oenb[64]    = 1'b0;
    la_data_in[64] = 1'b1;
    @(negedge clk);
    chk("soft_rst", {96'h0, la_data_out[31:0]}, 128'h0);
    la_oenb[64]    = 1'b1;
    la_data_in[64] = 1'b0;
    @(negedge clk);
    chk("frozen_zero", {96'h0, la_data_out[31:0]}, 128'h0);

    // Register table with the counter frozen
    foreach (vecs[i]) begin
      wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].wd, a1, a2, rd, c1);
      chk($sformatf("vec%0d_ack", i), {127'h0, a1}, {127'h0, vecs[i].exp_ack});
      chk($sformatf("vec%0d_ack_pulse", i), {127'h0, a2}, 128'h0);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd", i), {96'h0, rd}, {96'h0, vecs[i].exp_rd});
    end
    chk("table_count", {96'h0, la_data_out[31:0]}, 128'h11AD_33EF);
    chk("io_out_ab61", {90'h0, io_out}, {90'h0, 6'h0, 16'hAB61, 16'h0});
    chk("la_out_upper", {48'h0, la_data_out[127:48]}, 128'h0);

    // WB write beats a same-cycle LA load
    la_oenb[65]       = 1'b1;
    la_data_in[65]    = 1'b0;
    la_oenb[63:32]    = 32'h0;
    la_data_in[63:32] = 32'h1234_5678;
    wb_xfer(1'b1, 32'h3000_0000, 4'hF, 32'hCAFE_0000, a1, a2, rd, c1);
    chk("wb_beats_la", {96'h0, c1}, 128'hCAFE_0000);
    la_oenb[63:32]    = 32'hFFFF_FFFF;
    la_data_in[63:32] = 32'h0;
    @(negedge clk);
    chk("la_after_wb", {96'h0, la_data_out[31:0]}, 128'h1234_5679);

    // Reset arriving with a write in flight
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_we_i  = 1'b1;
    wbs.wbs_adr_i = 32'h3000_0004;
    wbs.wbs_sel_i = 4'hF;
    wbs.wbs_dat_i = 32'h0000_1111;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ack", {127'h0, wbs.wbs_ack_o}, 128'h0);
    chk("abort_la_out", la_data_out, 128'h0);
    chk("abort_dat", {96'h0, wbs.wbs_dat_o}, 128'h0);
    @(negedge clk);
    chk("abort_ack2", {127'h0, wbs.wbs_ack_o}, 128'h0);
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_no_write", {90'h0, io_out}, 128'h0);
    chk("abort_count_runs", {96'h0, la_data_out[31:0]}, 128'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
